udp_tx_fifo_ctrl: RTL and testbench



---
 rtl/udp_tx_fifo_pkg.sv | 16 +
 rtl/udp_tx_fifo_ctrl.sv | 79 +++++++
 tb/tb_udp_tx_fifo_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_fifo_pkg.sv
// Shared sizing helpers and default thresholds
// for the UDP transmit FIFO controller.
package udp_tx_fifo_pkg;

  localparam int AF_MARGIN  = 2;
  localparam int AE_DEFAULT = 2;

  function automatic int fifo_depth(input int aw);
    return 2 ** aw;
  endfunction

  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/udp_tx_fifo_ctrl.sv
// Pointer, flag and registered read-data control
// for the UDP TX FIFO in front of a combinational-read RAM.
import udp_tx_fifo_pkg::*;

module udp_tx_fifo_ctrl #(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int ALMOST_FULL_NUM  =
    fifo_depth(ADDR_WIDTH) - AF_MARGIN,
  parameter int ALMOST_EMPTY_NUM = AE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  wr_err,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_NUM);
  localparam logic [PW-1:0] ONE   = PW'(1);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push;
  logic          pop;

  // MSB is the wrap flag; equal low bits with
  // differing wrap flags means the RAM is full.
  assign empty = (wptr == rptr);
  assign full  =
    (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
    (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  assign ram_wr_en   = push;
  assign ram_wr_addr = wptr[ADDR_WIDTH-1:0];
  assign ram_wr_data = wr_data;
  assign ram_rd_addr = rptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
      wr_err  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      wr_err <= wr_en && full;
      rd_err <= rd_en && empty;
      if (push)
        wptr <= wptr + ONE;
      if (pop) begin
        rptr    <= rptr + ONE;
        rd_data <= ram_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_udp_tx_fifo_ctrl.sv
// Scoreboard bench for udp_tx_fifo_ctrl with a
// queue-based reference model and a behavioural RAM.
module tb_udp_tx_fifo_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic [7:0] rd_data;
    int         count;
    logic       empty;
    logic       full;
    logic       ae;
    logic       af;
    logic       wr_err;
    logic       rd_err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          full, almost_full, wr_err;
  logic          empty, almost_empty, rd_err;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;

  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad = 0;

  logic [7:0] mq[$];
  logic [7:0] last_rd = 8'h00;
  exp_t       expq[$];

  always #5 clk = ~clk;

  udp_tx_fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .almost_full(almost_full),
    .wr_err(wr_err),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .almost_empty(almost_empty),
    .rd_err(rd_err),
    .count(count),
    .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  always @(posedge clk)
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  assign ram_rd_data = mem[ram_rd_addr];

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, a, e, $time);
    end
  endtask

  function automatic exp_t model_state(bit we, bit re);
    exp_t e;
    e.rd_data = last_rd;
    e.count   = mq.size();
    e.empty   = (mq.size() == 0);
    e.full    = (mq.size() == DEPTH);
    e.ae      = (mq.size() <= 2);
    e.af      = (mq.size() >= DEPTH - 2);
    e.wr_err  = we;
    e.rd_err  = re;
    return e;
  endfunction

  // One clock of stimulus: drive, check the RAM
  // strobe, advance the model, queue the outcome.
  task automatic step(bit w, bit r, logic [7:0] d);
    int  n;
    bit  aw, ar;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    wr_data = d;
    n = mq.size();
    aw = w && (n < DEPTH);
    ar = r && (n > 0);
    #1;
    chk("ram_wr_en", ram_wr_en, aw);
    if (ar) last_rd = mq.pop_front();
    if (aw) mq.push_back(d);
    expq.push_back(model_state(w && !aw, r && !ar));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    mq.delete();
    last_rd = 8'h00;
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_errs", {wr_err, rd_err}, 0);
    expq.push_back(model_state(0, 0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("rd_data", rd_data, e.rd_data);
        chk("count", count, e.count);
        chk("empty", empty, e.empty);
        chk("full", full, e.full);
        chk("almost_empty", almost_empty, e.ae);
        chk("almost_full", almost_full, e.af);
        chk("wr_err", wr_err, e.wr_err);
        chk("rd_err", rd_err, e.rd_err);
      end
    end
  end

  initial begin : driver
    int pw, pr;
    do_reset();
    // fill past full
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
    step(1, 0, 8'hFF);
    // drain past empty
    for (int i = 0; i < 17; i++) step(0, 1, 8'h00);
    // simultaneous while empty
    step(1, 1, 8'hA5);
    step(0, 1, 8'h00);
    // simultaneous while full
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h40 + i));
    step(1, 1, 8'hEE);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00);
    // streaming across pointer wraps at occupancy 3
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h80 + i));
    for (int i = 0; i < 40; i++) step(1, 1, 8'(8'h90 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00);
    // reset with 5 words stored
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i));
    do_reset();
    step(0, 1, 8'h00);
    // random traffic with drifting bias
    for (int i = 0; i < 10000; i++) begin
      if (i % 400 == 0) begin
        pw = $urandom_range(20, 80);
        pr = $urandom_range(20, 80);
      end
      step($urandom_range(99) < pw,
           $urandom_range(99) < pr,
           8'($urandom));
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
